// File: rtl/pla_pkg.sv
// Shared defaults and row record for the programmable AND-OR evaluator.
package pla_pkg;

  localparam int PLA_N_IN    = 12;
  localparam int PLA_N_OUT   = 7;
  localparam int PLA_N_TERMS = 16;

  // One product-term row at the default widths: enable, AND-plane care mask,
  // required literal values and the OR-plane column selection.
  typedef struct packed {
    logic                 en;
    logic [PLA_N_IN-1:0]  care;
    logic [PLA_N_IN-1:0]  val;
    logic [PLA_N_OUT-1:0] or_mask;
  } term_row_t;

endpackage

// File: rtl/pla_term_match.sv
// One AND-plane row: reports whether an enabled row's cared-for literals all
// agree with the input vector. Purely combinational.
module pla_term_match
  import pla_pkg::*;
#(
  parameter int N_IN = PLA_N_IN
) (
  input  logic            i_en,
  input  logic [N_IN-1:0] i_care,
  input  logic [N_IN-1:0] i_val,
  input  logic [N_IN-1:0] i_pi,
  output logic            o_match
);

  // A row with an empty care mask matches every vector once enabled.
  assign o_match = i_en & ~|((i_pi ^ i_val) & i_care);

endmodule

// File: rtl/pla_eval_pipe.sv
// Programmable two-level AND-OR evaluator with a two-stage valid/ready
// pipeline: stage 1 holds the row match vector, stage 2 holds po and hits.
// The table can only change while the pipeline is empty, so every vector is
// evaluated against one consistent table.
module pla_eval_pipe
  import pla_pkg::*;
#(
  parameter int N_IN    = PLA_N_IN,
  parameter int N_OUT   = PLA_N_OUT,
  parameter int N_TERMS = PLA_N_TERMS,
  localparam int TW     = (N_TERMS > 1) ? $clog2(N_TERMS) : 1,
  localparam int CW     = $clog2(N_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  output logic             cfg_ready,
  input  logic [TW-1:0]    cfg_term,
  input  logic             cfg_en,
  input  logic [N_IN-1:0]  cfg_care,
  input  logic [N_IN-1:0]  cfg_val,
  input  logic [N_OUT-1:0] cfg_or,
  input  logic             cfg_inv_we,
  input  logic [N_OUT-1:0] cfg_inv,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  pi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] po,
  output logic [CW-1:0]    hits
);

  typedef struct packed {
    logic             en;
    logic [N_IN-1:0]  care;
    logic [N_IN-1:0]  val;
    logic [N_OUT-1:0] or_mask;
  } row_t;

  row_t               r_rows [N_TERMS];
  logic [N_OUT-1:0]   r_inv;
  logic               r_s1_valid;
  logic [N_TERMS-1:0] r_s1_match;
  logic               r_out_valid;
  logic [N_OUT-1:0]   r_po;
  logic [CW-1:0]      r_hits;

  logic               w_s1_adv;
  logic               w_s2_adv;
  logic               w_cfg_ready;
  logic               w_in_ready;
  logic               w_in_fire;
  logic               w_row_wr;
  logic               w_inv_wr;
  logic [N_TERMS-1:0] w_match;
  logic [N_OUT-1:0]   w_or_hit;
  logic [CW-1:0]      w_hits;

  // Handshake: a stage may load when it is empty or its contents move on.
  // A config strobe blocks new input even if the strobe itself is not yet
  // accepted, so the host's hold-until-accepted drains the pipeline.
  assign w_s2_adv    = ~r_out_valid | out_ready;
  assign w_s1_adv    = ~r_s1_valid | w_s2_adv;
  assign w_cfg_ready = ~r_s1_valid & ~r_out_valid;
  assign w_in_ready  = w_s1_adv & ~cfg_we & ~cfg_inv_we;
  assign w_in_fire   = in_valid & w_in_ready;
  assign w_row_wr    = cfg_we & w_cfg_ready;
  assign w_inv_wr    = cfg_inv_we & w_cfg_ready;

  assign cfg_ready = w_cfg_ready;
  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign po        = r_po;
  assign hits      = r_hits;

  // AND plane: one matcher per row against the live input vector.
  for (genvar g = 0; g < N_TERMS; g++) begin : g_row
    pla_term_match #(.N_IN(N_IN)) u_match (
      .i_en    (r_rows[g].en),
      .i_care  (r_rows[g].care),
      .i_val   (r_rows[g].val),
      .i_pi    (pi),
      .o_match (w_match[g])
    );
  end

  // Table and polarity writes; an index with no row decodes to no write.
  // NOTE: the table is reset on purpose -- it is flop-based and the reset
  // state (all rows disabled) is architecturally visible, unlike a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N_TERMS; r++) r_rows[r] <= '0;
      r_inv <= '0;
    end else begin
      for (int r = 0; r < N_TERMS; r++) begin
        if (w_row_wr && (cfg_term == TW'(r))) begin
          r_rows[r] <= '{en: cfg_en, care: cfg_care, val: cfg_val, or_mask: cfg_or};
        end
      end
      if (w_inv_wr) r_inv <= cfg_inv;
    end
  end

  // OR plane on the registered match vector.
  // NOTE: always_comb outputs get a default first so every path assigns them
  // and no latch is inferred; the loop then accumulates with blocking '='.
  always_comb begin
    w_or_hit = '0;
    for (int j = 0; j < N_OUT; j++) begin
      for (int r = 0; r < N_TERMS; r++) begin
        w_or_hit[j] = w_or_hit[j] | (r_s1_match[r] & r_rows[r].or_mask[j]);
      end
    end
  end

  // Matched-row count; CW bits hold N_TERMS without overflow.
  always_comb begin
    w_hits = '0;
    for (int r = 0; r < N_TERMS; r++) w_hits = w_hits + CW'(r_s1_match[r]);
  end

  // Stage 1: capture the match vector of the accepted input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_match <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= w_in_fire;
      if (w_in_fire) r_s1_match <= w_match;
    end
  end

  // Stage 2: result register, held while the sink stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_po        <= '0;
      r_hits      <= '0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_po   <= w_or_hit ^ r_inv;
        r_hits <= w_hits;
      end
    end
  end

endmodule

// File: tb/tb_pla_eval_pipe.sv
// Self-checking bench for pla_eval_pipe: directed vector tables, stall and
// config corner sequences, then randomized traffic scored against a
// behavioural table model.
module tb_pla_eval_pipe;
  import pla_pkg::*;

  localparam int NI = PLA_N_IN;
  localparam int NO = PLA_N_OUT;
  localparam int NT = PLA_N_TERMS;
  localparam int TW = $clog2(NT);
  localparam int CW = $clog2(NT + 1);

  typedef struct packed {
    logic [NO-1:0] po;
    logic [CW-1:0] hits;
  } res_t;

  typedef struct {
    logic [NI-1:0] pi;
    logic [NO-1:0] po;
    logic [CW-1:0] hits;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we, cfg_ready, cfg_en, cfg_inv_we;
  logic [TW-1:0] cfg_term;
  logic [NI-1:0] cfg_care, cfg_val;
  logic [NO-1:0] cfg_or, cfg_inv;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [NI-1:0] pi;
  logic [NO-1:0] po;
  logic [CW-1:0] hits;

  always #5 clk = ~clk;

  pla_eval_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_term(cfg_term), .cfg_en(cfg_en),
    .cfg_care(cfg_care), .cfg_val(cfg_val), .cfg_or(cfg_or),
    .cfg_inv_we(cfg_inv_we), .cfg_inv(cfg_inv),
    .in_valid(in_valid), .in_ready(in_ready), .pi(pi),
    .out_valid(out_valid), .out_ready(out_ready), .po(po), .hits(hits)
  );

  term_row_t     m_rows [NT];
  logic [NO-1:0] m_inv;
  res_t          sb [$];
  int            total = 0;
  int            bad   = 0;
  int            n_out = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a row hits when enabled and every cared-for bit of pi equals
  // the stored value; outputs OR the selected columns, then apply polarity.
  function automatic res_t model_eval(input logic [NI-1:0] v);
    res_t          r;
    int            n = 0;
    logic [NO-1:0] acc = '0;
    for (int t = 0; t < NT; t++) begin
      if (m_rows[t].en && ((v & m_rows[t].care) == (m_rows[t].val & m_rows[t].care))) begin
        n++;
        acc |= m_rows[t].or_mask;
      end
    end
    r.po   = acc ^ m_inv;
    r.hits = CW'(n);
    return r;
  endfunction

  function automatic term_row_t rand_row();
    term_row_t r;
    r.en      = ($urandom_range(0, 3) != 0);
    r.care    = NI'($urandom & $urandom & $urandom);
    r.val     = NI'($urandom);
    r.or_mask = NO'($urandom);
    return r;
  endfunction

  task automatic model_reset();
    for (int t = 0; t < NT; t++) m_rows[t] = '0;
    m_inv = '0;
    sb.delete();
  endtask

  // One clock: sample handshakes at the falling edge, advance the model and
  // scoreboard, then return 1 time unit after the rising edge.
  task automatic cycle();
    logic fin, fout, fcfg, finv;
    res_t got, exp;
    @(negedge clk);
    fin  = in_valid & in_ready;
    fout = out_valid & out_ready;
    fcfg = cfg_we & cfg_ready;
    finv = cfg_inv_we & cfg_ready;
    got.po   = po;
    got.hits = hits;
    if (fout) begin
      n_out++;
      check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        check("sb_po", 32'(got.po), 32'(exp.po));
        check("sb_hits", 32'(got.hits), 32'(exp.hits));
      end
    end
    if (fin) sb.push_back(model_eval(pi));
    if (fcfg && (int'(cfg_term) < NT)) begin
      m_rows[int'(cfg_term)] = '{en: cfg_en, care: cfg_care, val: cfg_val, or_mask: cfg_or};
    end
    if (finv) m_inv = cfg_inv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cfg_we = 1'b0; cfg_inv_we = 1'b0; cfg_term = '0; cfg_en = 1'b0;
    cfg_care = '0; cfg_val = '0; cfg_or = '0; cfg_inv = '0;
    in_valid = 1'b0; pi = '0; out_ready = 1'b1;
  endtask

  task automatic write_cfg(input logic we, input int term, input term_row_t row,
                           input logic inv_we, input logic [NO-1:0] inv);
    logic acc;
    logic done = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    cfg_we = we; cfg_term = TW'(term); cfg_en = row.en; cfg_care = row.care;
    cfg_val = row.val; cfg_or = row.or_mask; cfg_inv_we = inv_we; cfg_inv = inv;
    for (int k = 0; k < 40 && !done; k++) begin
      acc = cfg_ready;
      cycle();
      done = acc;
    end
    check("cfg_accepted", 32'(done), 32'd1);
    cfg_we = 1'b0; cfg_inv_we = 1'b0;
  endtask

  task automatic send_one(input logic [NI-1:0] v, input logic [NO-1:0] epo,
                          input logic [CW-1:0] ehits, input string name);
    logic acc;
    logic done = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; pi = v;
    for (int k = 0; k < 20 && !done; k++) begin
      #1;
      acc = in_ready;
      cycle();
      done = acc;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 20 && !out_valid; k++) cycle();
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_po"}, 32'(po), 32'(epo));
    check({name, "_hits"}, 32'(hits), 32'(ehits));
    cycle();
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 60 && (sb.size() > 0 || out_valid); k++) cycle();
    check("drain_sb_empty", 32'(sb.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          tab2 [5];
    term_row_t     row;
    logic [NO-1:0] hold_po;
    logic [CW-1:0] hold_hits;
    logic          acc, pend_we, pend_inv;
    logic [NO-1:0] iv;
    int            sent, out_base;

    tab2[0] = '{pi: 12'h036, po: 7'h01, hits: 5'd1};
    tab2[1] = '{pi: 12'h03E, po: 7'h00, hits: 5'd0};
    tab2[2] = '{pi: 12'hA36, po: 7'h43, hits: 5'd2};
    tab2[3] = '{pi: 12'hA00, po: 7'h42, hits: 5'd1};
    tab2[4] = '{pi: 12'hF37, po: 7'h01, hits: 5'd1};

    // Reset state.
    idle();
    model_reset();
    rst_n = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_po", 32'(po), 32'd0);
    check("rst_hits", 32'(hits), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Empty table, two-cycle latency.
    pi = 12'h036; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("lat_in_ready", 32'(in_ready), 32'd1);
    cycle();
    in_valid = 1'b0;
    check("lat_valid_t1", 32'(out_valid), 32'd0);
    cycle();
    check("lat_valid_t2", 32'(out_valid), 32'd1);
    check("lat_po", 32'(po), 32'd0);
    check("lat_hits", 32'(hits), 32'd0);
    cycle();

    // All rows disabled: po follows polarity only.
    write_cfg(1'b0, 0, '0, 1'b1, 7'h05);
    send_one(12'h5A5, 7'h05, 5'd0, "dis_inv");
    write_cfg(1'b0, 0, '0, 1'b1, 7'h00);

    // Directed table with two rows.
    write_cfg(1'b1, 0, '{en: 1'b1, care: 12'h07E, val: 12'h036, or_mask: 7'h01}, 1'b0, '0);
    write_cfg(1'b1, 5, '{en: 1'b1, care: 12'hF00, val: 12'hA00, or_mask: 7'h42}, 1'b0, '0);
    for (int i = 0; i < 5; i++) send_one(tab2[i].pi, tab2[i].po, tab2[i].hits, "tab2");

    // Every row matches; last row and polarity written in the same strobe.
    for (int t = 0; t < NT - 1; t++)
      write_cfg(1'b1, t, '{en: 1'b1, care: '0, val: '0, or_mask: 7'h7F}, 1'b0, '0);
    write_cfg(1'b1, NT - 1, '{en: 1'b1, care: '0, val: '0, or_mask: 7'h7F}, 1'b1, 7'h05);
    for (int i = 0; i < 4; i++) send_one(NI'($urandom), 7'h7A, 5'd16, "all_hit");

    // Eight back-to-back vectors with the sink stalled for cycles 3..5.
    for (int t = 0; t < NT; t++) write_cfg(1'b1, t, rand_row(), 1'b0, '0);
    write_cfg(1'b0, 0, '0, 1'b1, NO'($urandom));
    sent = 0;
    out_base = n_out;
    hold_po = '0;
    hold_hits = '0;
    for (int c = 0; c < 40 && (sent < 8 || sb.size() > 0 || out_valid); c++) begin
      in_valid  = (sent < 8);
      pi        = NI'($urandom);
      out_ready = !(c >= 3 && c <= 5);
      #1;
      if (c == 3) begin
        hold_po = po;
        hold_hits = hits;
        check("stall_valid", 32'(out_valid), 32'd1);
      end
      if (c == 4 || c == 5) begin
        check("stall_hold_valid", 32'(out_valid), 32'd1);
        check("stall_hold_po", 32'(po), 32'(hold_po));
        check("stall_hold_hits", 32'(hits), 32'(hold_hits));
        check("stall_in_ready", 32'(in_ready), 32'd0);
      end
      if (c == 6) check("no_bubble_in_ready", 32'(in_ready), 32'd1);
      acc = in_valid & in_ready;
      cycle();
      if (acc) sent++;
    end
    check("stream_out_count", 32'(n_out - out_base), 32'd8);
    drain();

    // Config strobe against a stalled full output stage.
    for (int t = 0; t < NT; t++) write_cfg(1'b1, t, '0, 1'b0, '0);
    write_cfg(1'b0, 0, '0, 1'b1, '0);
    out_ready = 1'b0; in_valid = 1'b1; pi = 12'h123;
    cycle();
    in_valid = 1'b0;
    cycle();
    row = '{en: 1'b1, care: 12'hFFF, val: 12'hABC, or_mask: 7'h40};
    cfg_we = 1'b1; cfg_term = TW'(3); cfg_en = row.en; cfg_care = row.care;
    cfg_val = row.val; cfg_or = row.or_mask; in_valid = 1'b1;
    #1;
    check("cfgblk_out_valid", 32'(out_valid), 32'd1);
    check("cfgblk_cfg_ready", 32'(cfg_ready), 32'd0);
    check("cfgblk_in_ready", 32'(in_ready), 32'd0);
    cycle();
    cycle();
    check("cfgblk_still_blocked", 32'(cfg_ready), 32'd0);
    write_cfg(1'b1, 3, row, 1'b0, '0);
    send_one(12'hABC, 7'h40, 5'd1, "cfg_after_drain");

    // Reset with both stages full.
    out_ready = 1'b0; in_valid = 1'b1; pi = 12'hABC;
    cycle();
    cycle();
    in_valid = 1'b0;
    #1;
    check("prerst_full", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_po", 32'(po), 32'd0);
    check("midrst_hits", 32'(hits), 32'd0);
    model_reset();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle();
    send_one(12'hABC, 7'h00, 5'd0, "table_cleared");

    // Randomized traffic with interleaved, held config writes.
    pend_we = 1'b0; pend_inv = 1'b0; iv = '0; row = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pend_we && $urandom_range(0, 19) == 0) begin
        pend_we = 1'b1;
        row = rand_row();
        cfg_term = TW'($urandom_range(0, NT - 1));
      end
      if (!pend_inv && $urandom_range(0, 39) == 0) begin
        pend_inv = 1'b1;
        iv = NO'($urandom);
      end
      cfg_we = pend_we; cfg_en = row.en; cfg_care = row.care; cfg_val = row.val;
      cfg_or = row.or_mask; cfg_inv_we = pend_inv; cfg_inv = iv;
      in_valid  = ($urandom_range(0, 9) < 7);
      pi        = NI'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      acc = cfg_ready;
      cycle();
      if (acc) begin
        pend_we = 1'b0;
        pend_inv = 1'b0;
      end
    end
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
